// File: rtl/seq_det_prog_if.sv
// rtl/seq_det_prog_if.sv - config, serial data and status bundle for seq_det_prog
// Ports (master drives / slave receives):
//   cfg_we, pat_in, len_in, ovl_in : run-time pattern configuration write
//   din_valid, din                 : qualified serial bit stream
//   cnt_clr                        : match counter clear
//   det, match_cnt, cfg_err        : detector status back to the master
interface seq_det_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic                 cfg_we;
    logic [MAX_LEN-1:0]   pat_in;
    logic [LEN_W-1:0]     len_in;
    logic                 ovl_in;
    logic                 din_valid;
    logic                 din;
    logic                 cnt_clr;
    logic                 det;
    logic [CNT_W-1:0]     match_cnt;
    logic                 cfg_err;

    modport master (
        output cfg_we, pat_in, len_in, ovl_in, din_valid, din, cnt_clr,
        input  det, match_cnt, cfg_err
    );

    modport slave (
        input  cfg_we, pat_in, len_in, ovl_in, din_valid, din, cnt_clr,
        output det, match_cnt, cfg_err
    );
endinterface

// File: rtl/seq_det_prog.sv
// rtl/seq_det_prog.sv - programmable serial bit-pattern detector with match counter
// Ports:
//   i_clk : clock, all state on the rising edge
//   i_rst : synchronous active-high reset
//   bus   : seq_det_prog_if slave (config write, serial data, cnt_clr in;
//           det pulse, saturating match_cnt, cfg_err pulse out)
module seq_det_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    seq_det_prog_if.slave       bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_ARMED = 1'b1;

    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [0:0]         r_state;
    logic               r_det;
    logic               r_cfg_err;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_len_ok;
    logic               w_accept;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_full_next;
    logic               w_match;

    assign w_len_ok    = (bus.len_in != '0) && (bus.len_in <= LEN_W'(MAX_LEN));
    // A config write always wins over the data bit on the same edge.
    assign w_accept    = bus.din_valid && !bus.cfg_we;
    assign w_hist_next = {r_hist[MAX_LEN-2:0], bus.din};
    // Once armed, fill sits at len so the window keeps sliding.
    assign w_fill_next = (r_state == S_ARMED) ? r_fill : r_fill + LEN_W'(1);
    assign w_full_next = (w_fill_next == r_len);

    // Only the youngest len bits of history take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_match = w_accept && w_full_next &&
                     (((w_hist_next ^ r_pat) & w_mask) == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pat     <= '0;
            r_len     <= LEN_W'(4);
            r_ovl     <= 1'b1;
            r_hist    <= '0;
            r_fill    <= '0;
            r_state   <= S_FILL;
            r_det     <= 1'b0;
            r_cfg_err <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_det     <= w_match;
            r_cfg_err <= bus.cfg_we && !w_len_ok;

            if (bus.cfg_we) begin
                if (w_len_ok) begin
                    r_pat   <= bus.pat_in;
                    r_len   <= bus.len_in;
                    r_ovl   <= bus.ovl_in;
                    r_hist  <= '0;
                    r_fill  <= '0;
                    r_state <= S_FILL;
                end
            end else if (bus.din_valid) begin
                r_hist <= w_hist_next;
                if (w_match && !r_ovl) begin
                    // Non-overlap: history is kept but fill gates it out.
                    r_fill  <= '0;
                    r_state <= S_FILL;
                end else begin
                    r_fill  <= w_fill_next;
                    r_state <= w_full_next ? S_ARMED : S_FILL;
                end
            end

            if (bus.cnt_clr) begin
                r_cnt <= '0;
            end else if (w_match && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.det       = r_det;
    assign bus.match_cnt = r_cnt;
    assign bus.cfg_err   = r_cfg_err;
endmodule
